// File: rtl/button_debounce_ctrl.sv
// button_debounce_ctrl: synchronized, debounced push-buttons with sticky W1C press/release flags
module button_debounce_ctrl #(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              cpuclk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic [31:0]       addr,
  input  logic              wen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [N_BTN-1:0]  btn_level,
  output logic              btn_irq
);
  logic [N_BTN-1:0] s1, s2, stable, press, rel, term, rise, fall, press_nx, rel_nx, clr_p, clr_r;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic irq_en;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};
  always_comb begin
    for (int i = 0; i < N_BTN; i++) term[i] = cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1);
  end
  assign rise = s2 & ~stable & term;
  assign fall = ~s2 & stable & term;
  assign clr_p = (wen && addr[3:2] == 2'd1) ? wdata[N_BTN-1:0] : '0;
  assign clr_r = (wen && addr[3:2] == 2'd2) ? wdata[N_BTN-1:0] : '0;
  // Set beats clear when an event and a W1C land on the same edge
  assign press_nx = (press & ~clr_p) | rise;
  assign rel_nx = (rel & ~clr_r) | fall;
  assign btn_level = stable;
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      press <= '0;
      rel <= '0;
      irq_en <= 1'b0;
      btn_irq <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      press <= press_nx;
      rel <= rel_nx;
      btn_irq <= irq_en & |press_nx;
      if (wen && addr[3:2] == 2'd3) irq_en <= wdata[0];
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (term[i]) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_comb begin
    rdata = addr[3:2] == 2'd0 ? 32'(stable) :
            addr[3:2] == 2'd1 ? 32'(press) :
            addr[3:2] == 2'd2 ? 32'(rel) : {31'd0, irq_en};
  end
endmodule

// File: doc/button_debounce_ctrl.md
# button_debounce_ctrl

Memory-mapped push-button input peripheral between the five raw FPGA button pins and the bus bridge's button read port. It synchronizes each button, debounces it with a per-button stability counter, and keeps sticky press/release event flags that software clears with write-1-to-clear. The bridge reads it like any other peripheral, using the same `cpuclk`/`rst` domain as the digit display.

## Interface
- `N_BTN`, default 5: number of buttons. Legal range 1..32.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a new level. This is 10 ms at 25 MHz. Minimum 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width. Derived; do not override.

Ports:
- `cpuclk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Clears all state.
- `btn_raw`  in  N_BTN  raw, asynchronous button pins. 1 = pressed.
- `addr`  in  32  bus byte address. Only `addr[3:2]` is decoded.
- `wen`  in  1  bus write strobe, sampled on the rising edge of `cpuclk`.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  combinational read data for `addr`.
- `btn_level`  out  N_BTN  debounced level, registered.
- `btn_irq`  out  1  registered OR of all press flags.

## Operation
- **Synchronizer:** two flops per bit, `btn_raw` → `s1` → `s2`. Reset value 0.
- **Debounce, per bit i:**
  - If `s2[i] == stable[i]`: `cnt[i]` ← 0.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i]` ← `s2[i]` and `cnt[i]` ← 0.
  - Otherwise: `cnt[i]` ← `cnt[i]+1`.
  - The counter never wraps. Any glitch back to the old level restarts the count from 0.
- `btn_level` = `stable`.
- **Event detect, per bit:**
  - `rise[i]` = `s2[i] & ~stable[i]` & terminal count. The bit is about to go 0→1.
  - `fall[i]` is the same with polarities swapped.
  - A rise sets `press[i]` and a fall sets `release[i]` on the same edge that `stable[i]` updates.
- **Register map** (word offset from `addr[3:2]`):
  - 0: LEVEL. RO, `{0, stable}`.
  - 1: PRESS. W1C, `{0, press}`.
  - 2: RELEASE. W1C, `{0, release}`.
  - 3: CTRL. RW, bit0 = `irq_en`, reset 0. Other bits read 0.
- **Writes:**
  - Writes to LEVEL are ignored. Write bits above `N_BTN` are ignored.
  - W1C: `press` ← (`press` & ~`wdata[N_BTN-1:0]`) | `rise`. Same rule for `release` with `fall`.
  - When an event and a clear hit the same bit on the same edge, set wins.
- **Interrupt:** `btn_irq` ← `irq_en` & |(next `press`). Registered, so it updates on the same edge as `press`.
- **Reads:** combinational, with no side effects. Reads never clear flags.
- **Reset:** `s1`, `s2`, `stable`, `cnt`, `press`, `release`, `irq_en`, `btn_level` and `btn_irq` are all 0. `rdata` follows the reset state, so every offset reads 0. Asserting reset mid-count discards the count. A button held through reset is reported as a fresh press after `DEBOUNCE_CYCLES`+2 edges post-release of reset.

## Timing
- **Raw to level:** with a clean `btn_raw` step before edge k, `s2` changes at edge k+1. `stable`, `btn_level`, the event flag and `btn_irq` all change at edge k+`DEBOUNCE_CYCLES`+1.
- **Clear:** a W1C write at edge k clears the flag at edge k. `btn_irq` deasserts at edge k. `rdata` shows the cleared value in the cycle after edge k.
- **Bus:** no wait states. Reads are valid in the same cycle `addr` is presented. Writes take effect on the sampling edge.
- **Pulses:** any pulse on `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no level change and no event.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `N_BTN=5`.
1. **Reset:** assert `rst` asynchronously mid-cycle. All outputs go 0 immediately. Reading offsets 0–3 returns 0x0.
2. **Clean press:** `btn_raw`=5'b00001 held. `btn_level[0]` rises exactly 5 edges after the first sampling edge. PRESS reads 0x1. With `irq_en`=1, `btn_irq`=1. RELEASE stays 0x0.
3. **Bounce:** toggle `btn_raw[2]` 1,0,1,0 every 2 cycles, then hold at 1. No change until 4 consecutive stable `s2` cycles. Exactly one press event; PRESS reads 0x4.
4. **W1C and collision:** with PRESS=0x3, write 0x1 → PRESS reads 0x2. Write 0x2 on the same edge a new rise sets bit 1 → bit 1 stays 1.
5. **Release and irq gating:** release button 0 → RELEASE reads 0x1 after 5 edges. With `irq_en`=0 and PRESS≠0, `btn_irq` stays 0. Writing CTRL=1 raises `btn_irq` on the next edge.
6. **Reset mid-count:** pulse `rst` after 2 of 4 counting cycles while the button is held. After release of reset, `btn_level` rises only after a full 4+1 edges and a new press event is set.
